alu_nbit_seq: RTL and testbench

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

---
 rtl/alu_nbit_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// Sequential N-bit ALU with a valid/ready handshake. Add, sub, logic ops and
// divide-by-zero finish at the accept edge; mul and div iterate one bit per cycle.
module alu_nbit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] wrk_hi;
  logic [WIDTH-1:0] wrk_lo;
  logic             is_div;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] imm_res;
  logic [WIDTH-1:0] imm_hi;
  logic             imm_cout;
  logic             imm_ovf;
  logic             imm_dz;
  logic             imm_multi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle results, evaluated directly from the request inputs
  always_comb begin
    add_full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_full  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    imm_res   = '0;
    imm_hi    = '0;
    imm_cout  = 1'b0;
    imm_ovf   = 1'b0;
    imm_dz    = 1'b0;
    imm_multi = (sel == 3'b010) || ((sel == 3'b011) && (b != '0));
    case (sel)
      3'b000: begin
        imm_res  = add_full[WIDTH-1:0];
        imm_cout = add_full[WIDTH];
        imm_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        imm_res  = sub_full[WIDTH-1:0];
        imm_cout = sub_full[WIDTH];
        imm_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: begin
        imm_res = '1;
        imm_hi  = a;
        imm_dz  = 1'b1;
      end
      3'b100:  imm_res = a & b;
      3'b101:  imm_res = a | b;
      3'b110:  imm_res = a ^ b;
      3'b111:  imm_res = ~(a ^ b);
      default: imm_res = '0;
    endcase
  end

  // One iteration step; both algorithms leave {hi, lo} = {product hi, lo} or {rem, quo}
  always_comb begin
    mul_sum   = {1'b0, wrk_hi} + (wrk_lo[0] ? {1'b0, opb} : '0);
    div_shift = {wrk_hi, wrk_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    div_ge    = ~div_trial[WIDTH];
    if (is_div) begin
      step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {wrk_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], wrk_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      opb       <= '0;
      wrk_hi    <= '0;
      wrk_lo    <= '0;
      is_div    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opb    <= b;
            is_div <= sel[0];
            cnt    <= '0;
            wrk_hi <= '0;
            wrk_lo <= a;
            if (imm_multi) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              result    <= imm_res;
              result_hi <= imm_hi;
              cout      <= imm_cout;
              zero      <= (imm_res == '0);
              ovf       <= imm_ovf;
              dz        <= imm_dz;
            end
          end
        end
        BUSY: begin
          wrk_hi <= step_hi;
          wrk_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            result    <= step_lo;
            result_hi <= step_hi;
            cout      <= 1'b0;
            zero      <= (step_lo == '0);
            ovf       <= 1'b0;
            dz        <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Self-checking bench for alu_nbit_seq: directed corner vectors plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_nbit_seq;

  localparam int     W   = 16;
  localparam longint MOD = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         obs;
  logic [W-1:0] lastRes;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .cout(cout), .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic longint toSigned(input longint u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  // Reference behaviour from plain integer arithmetic
  function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t   e;
    longint ua, ub, cl, full, sv;
    ua = x; ub = y; cl = c;
    full = 0; sv = 0;
    e.res = '0; e.hi = '0; e.cout = 1'b0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (s)
      3'd0: begin
        full   = ua + ub + cl;
        e.res  = full[W-1:0];
        e.cout = (full >= MOD);
        sv     = toSigned(ua) + toSigned(ub) + cl;
        e.ovf  = (sv >= MOD / 2) || (sv < -(MOD / 2));
      end
      3'd1: begin
        full   = ua - ub - cl;
        e.res  = full[W-1:0];
        e.cout = (ua < ub + cl);
        sv     = toSigned(ua) - toSigned(ub) - cl;
        e.ovf  = (sv >= MOD / 2) || (sv < -(MOD / 2));
      end
      3'd2: begin
        full  = ua * ub;
        e.res = full[W-1:0];
        e.hi  = full[2*W-1:W];
        e.lat = W + 1;
      end
      3'd3: begin
        if (ub == 0) begin
          e.res = '1;
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          full  = ua / ub;
          e.res = full[W-1:0];
          full  = ua % ub;
          e.hi  = full[W-1:0];
          e.lat = W + 1;
        end
      end
      3'd4:    e.res = x & y;
      3'd5:    e.res = x | y;
      3'd6:    e.res = x ^ y;
      default: e.res = ~(x ^ y);
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Issue one request from IDLE, check timing and outputs, stall, then consume
  task automatic applyStimulus(input string tag, input logic [2:0] s, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic c, input int hold);
    exp_t e;
    int   lat;
    bit   busyReady;
    bit   holdBad;
    e = model(s, x, y, c);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1; sel = s; a = x; b = y; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sel = 3'($urandom);
    lat = 1;
    busyReady = 1'b0;
    if (!out_valid) checkOutput({tag, "_retain"}, 64'(result), 64'(lastRes));
    while (!out_valid && lat < 4 * W) begin
      if (in_ready) busyReady = 1'b1;
      in_valid = lat[0];
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    obs = '{res: result, hi: result_hi, cout: cout, zero: zero, ovf: ovf, dz: dz, lat: lat};
    checkOutput({tag, "_latency"}, 64'(lat), 64'(e.lat));
    checkOutput({tag, "_busy_ready"}, 64'(busyReady), 64'(1'b0));
    checkOutput({tag, "_result"}, 64'(result), 64'(e.res));
    checkOutput({tag, "_result_hi"}, 64'(result_hi), 64'(e.hi));
    checkOutput({tag, "_flags"}, 64'({cout, zero, ovf, dz}), 64'({e.cout, e.zero, e.ovf, e.dz}));
    holdBad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); sel = 3'($urandom);
      @(posedge clk); #1;
      if (!out_valid || result !== e.res || result_hi !== e.hi ||
          {cout, zero, ovf, dz} !== {e.cout, e.zero, e.ovf, e.dz}) holdBad = 1'b1;
    end
    if (hold > 0) checkOutput({tag, "_hold"}, 64'(holdBad), 64'(1'b0));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_consumed"}, 64'({out_valid, in_ready}), 64'(2'b01));
    lastRes = e.res;
  endtask

  initial begin
    bit quietBad;
    logic [2:0]   rs;
    logic [W-1:0] rx, ry;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sel = '0;
    lastRes = '0;
    #12;
    checkOutput("reset_result", 64'({result, result_hi}), 64'(0));
    checkOutput("reset_flags", 64'({cout, zero, ovf, dz}), 64'(0));
    checkOutput("reset_handshake", 64'({out_valid, in_ready}), 64'(2'b01));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    checkOutput("add_wrap_const", 64'({obs.res, obs.cout, obs.zero, obs.ovf}), 64'({16'h0000, 3'b110}));
    checkOutput("add_wrap_lat", 64'(obs.lat), 64'(1));

    applyStimulus("sub_ovf", 3'd1, 16'h8000, 16'h0001, 1'b0, 0);
    checkOutput("sub_ovf_const", 64'({obs.res, obs.cout, obs.ovf}), 64'({16'h7FFF, 2'b01}));

    applyStimulus("sub_borrow", 3'd1, 16'h0000, 16'h0000, 1'b1, 0);
    checkOutput("sub_borrow_const", 64'({obs.res, obs.cout}), 64'({16'hFFFF, 1'b1}));

    applyStimulus("mul_max", 3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    checkOutput("mul_max_const", 64'({obs.hi, obs.res}), 64'(32'hFFFE_0001));
    checkOutput("mul_max_lat", 64'(obs.lat), 64'(17));

    applyStimulus("div_basic", 3'd3, 16'h0064, 16'h0007, 1'b0, 0);
    checkOutput("div_basic_const", 64'({obs.res, obs.hi}), 64'(32'h000E_0002));

    applyStimulus("div_zero", 3'd3, 16'h1234, 16'h0000, 1'b0, 0);
    checkOutput("div_zero_const", 64'({obs.res, obs.hi, obs.dz}), 64'({32'hFFFF_1234, 1'b1}));
    checkOutput("div_zero_lat", 64'(obs.lat), 64'(1));

    // Reset in the middle of a multiply must discard it entirely
    in_valid = 1'b1; sel = 3'd2; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_outputs", 64'({out_valid, result, result_hi}), 64'(0));
    checkOutput("midrst_flags", 64'({cout, zero, ovf, dz}), 64'(0));
    checkOutput("midrst_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk) rst_n = 1'b1;
    quietBad = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) quietBad = 1'b1; end
    checkOutput("midrst_no_result", 64'(quietBad), 64'(1'b0));
    lastRes = '0;
    applyStimulus("post_reset_add", 3'd0, 16'h1234, 16'h4321, 1'b1, 0);

    applyStimulus("stall", 3'd6, 16'hA5A5, 16'h0FF0, 1'b0, 5);
    applyStimulus("add_ovf", 3'd0, 16'h7FFF, 16'h0000, 1'b1, 1);
    applyStimulus("sub_full_borrow", 3'd1, 16'h0000, 16'hFFFF, 1'b1, 0);
    applyStimulus("xnor_eq", 3'd7, 16'h5A5A, 16'h5A5A, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      rs = 3'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      if ($urandom_range(0, 7) == 0) ry = '0;
      else if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(1, 15));
      applyStimulus($sformatf("rand%0d_op%0d", i, rs), rs, rx, ry, 1'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
